tx_packet_queue: RTL and testbench

- Transmit-side buffer that sits directly upstream of the PPM Encoder.
- Accepts N_PKT-bit packets from the host side (switches, button logic or a future UART bridge) into a FIFO.
- Launches each packet into the Encoder using its start/avail handshake, then enforces a minimum inter-packet gap before the next launch.
- Replaces ad-hoc rate limiting at the top level and lets bursts of packets be queued without loss.

---
 rtl/tx_packet_queue.sv | 131 +++++++++++++
 tb/tb_tx_packet_queue.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_packet_queue.sv
// Transmit packet queue in front of the PPM Encoder: buffers host packets in a FIFO,
// launches each one with a start/avail handshake and enforces an idle gap between launches.
module tx_packet_queue #(
    parameter int unsigned N_PKT  = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned GAP_CT = 500_000,
    parameter int unsigned GAP_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_PKT-1:0]           wr_data,
    input  logic                       wr_en,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic [N_PKT-1:0]           enc_data,
    output logic                       enc_start,
    input  logic                       enc_avail,
    output logic                       busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]    DEPTH_C  = CW'(DEPTH);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CT == 0) ? '0 : GAP_W'(GAP_CT - 1);

    typedef enum logic [2:0] {IDLE, START, ACK, SEND, GAP} state_t;

    state_t           state;
    logic [N_PKT-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [GAP_W-1:0] gap_cnt;
    logic             pop;
    logic             push;
    logic             drop;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign busy  = (state != IDLE);

    // A pop frees the head slot in the same cycle, so a write at full still lands.
    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        drop = 1'b0;
        pop  = (state == IDLE) && !empty && enc_avail && !flush;
        push = wr_en && !flush && (!full || pop);
        drop = wr_en && !flush && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= drop;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            enc_data  <= '0;
            enc_start <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            enc_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        enc_data  <= mem[rd_ptr];
                        enc_start <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    state <= ACK;
                end
                ACK: begin
                    if (!enc_avail) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (enc_avail) begin
                        gap_cnt <= '0;
                        if (GAP_CT == 0) begin
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_packet_queue.sv
// Bench for tx_packet_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the launch handshake.
module tb_tx_packet_queue;

    localparam int unsigned N_PKT  = 8;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned GAP_CT = 10;
    localparam int unsigned GAP_W  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0;
    logic       flush = 1'b0;
    logic       enc_avail = 1'b0;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic [7:0] enc_data;
    logic       enc_start;
    logic       busy;

    tx_packet_queue #(
        .N_PKT (N_PKT),
        .DEPTH (DEPTH),
        .GAP_CT(GAP_CT),
        .GAP_W (GAP_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .flush    (flush),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .enc_data (enc_data),
        .enc_start(enc_start),
        .enc_avail(enc_avail),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: packet queue plus the phase of the current launch.
    typedef enum {PH_IDLE, PH_LAUNCH, PH_ACCEPT, PH_DONE, PH_GAP} ph_t;
    logic [7:0] mq[$];
    logic [7:0] m_data;
    bit         m_start;
    bit         m_ovf;
    ph_t        m_ph;
    int         m_gap_left;

    logic [7:0] launched[$];
    int         start_cyc[$];
    int         rise_cyc[$];

    task automatic model_reset();
        mq.delete();
        m_data     = '0;
        m_start    = 1'b0;
        m_ovf      = 1'b0;
        m_ph       = PH_IDLE;
        m_gap_left = 0;
    endtask

    task automatic model_step(input bit we, input logic [7:0] wd, input bit fl, input bit av);
        int n;
        bit launch;
        n      = mq.size();
        launch = (m_ph == PH_IDLE) && (n > 0) && av && !fl;
        m_ovf  = we && !fl && (n == DEPTH) && !launch;
        m_start = launch;
        case (m_ph)
            PH_IDLE:   if (launch) begin m_data = mq.pop_front(); m_ph = PH_LAUNCH; end
            PH_LAUNCH: m_ph = PH_ACCEPT;
            PH_ACCEPT: if (!av) m_ph = PH_DONE;
            PH_DONE: begin
                if (av) begin
                    if (GAP_CT == 0) m_ph = PH_IDLE;
                    else begin m_ph = PH_GAP; m_gap_left = GAP_CT; end
                end
            end
            PH_GAP: begin
                m_gap_left--;
                if (m_gap_left == 0) m_ph = PH_IDLE;
            end
            default: m_ph = PH_IDLE;
        endcase
        if (fl) mq.delete();
        else if (we && (n < DEPTH || launch)) mq.push_back(wd);
    endtask

    // Drive one cycle of inputs (called at a negedge) and advance to the next negedge.
    task automatic tick(input bit we, input logic [7:0] wd, input bit fl, input bit av);
        wr_en     = we;
        wr_data   = wd;
        flush     = fl;
        enc_avail = av;
        model_step(we, wd, fl, av);
        @(negedge clk);
        cyc++;
    endtask

    // Encoder stand-in: after each enc_start it drops avail, stays busy a while, then rises.
    task automatic encoder_run(input int max_ticks, output bit timed_out);
        int lo_wait;
        int hi_wait;
        bit av;
        lo_wait   = -1;
        hi_wait   = -1;
        av        = 1'b1;
        timed_out = 1'b1;
        for (int i = 0; i < max_ticks; i++) begin
            if (m_ph == PH_IDLE && mq.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
            if (enc_start) begin
                launched.push_back(enc_data);
                start_cyc.push_back(cyc);
                lo_wait = $urandom_range(0, 2);
            end else if (lo_wait > 0) begin
                lo_wait--;
            end else if (lo_wait == 0) begin
                av      = 1'b0;
                lo_wait = -1;
                hi_wait = $urandom_range(1, 6);
            end else if (hi_wait > 0) begin
                hi_wait--;
            end else if (hi_wait == 0) begin
                av      = 1'b1;
                hi_wait = -1;
                rise_cyc.push_back(cyc);
            end
            tick(1'b0, 8'h00, 1'b0, av);
        end
    endtask

    task automatic clear_logs();
        launched.delete();
        start_cyc.delete();
        rise_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        wr_en = 1'b0; flush = 1'b0; enc_avail = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (enc_data !== 8'h00) begin errors++; $display("FAIL reset_enc_data: got %h want 00", enc_data); end
        checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL reset_enc_start: got %b want 0", enc_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_packet();
        int t;
        int bad;
        t = cyc;
        tick(1'b1, 8'hA5, 1'b0, 1'b1);
        checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL single_t1_start: got %b want 0", enc_start); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_t1_count: got %0d want 1", count); end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (enc_start !== 1'b1) begin errors++; $display("FAIL single_t2_start: got %b want 1", enc_start); end
        checks++; if (enc_data !== 8'hA5) begin errors++; $display("FAIL single_t2_data: got %h want a5", enc_data); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_t2_count: got %0d want 0", count); end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL single_t3_start: got %b want 0", enc_start); end
        while (cyc < t + 40) tick(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1 || enc_data !== 8'hA5) begin errors++; $display("FAIL single_send_hold: got busy=%b data=%h want busy=1 data=a5", busy, enc_data); end
        bad = 0;
        for (int i = 0; i < int'(GAP_CT); i++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b1);
            if (busy !== 1'b1 || enc_data !== 8'hA5) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL single_gap_busy: got %0d bad gap cycles want 0", bad); end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_gap_end: got busy=%b want 0", busy); end
        checks++; if (count !== 4'd0 || enc_start !== 1'b0) begin errors++; $display("FAIL single_idle: got count=%0d start=%b want 0 0", count, enc_start); end
    endtask

    task automatic test_burst_order();
        bit to;
        for (int i = 1; i <= 8; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
        checks++; if (full !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL burst_full: got full=%b count=%0d want 1 8", full, count); end
        clear_logs();
        encoder_run(800, to);
        checks++; if (to) begin errors++; $display("FAIL burst_timeout: got timeout want drained"); end
        checks++; if (launched.size() != 8) begin errors++; $display("FAIL burst_launch_count: got %0d want 8", launched.size()); end
        for (int k = 0; k < launched.size() && k < 8; k++) begin
            checks++; if (launched[k] !== 8'(k + 1)) begin errors++; $display("FAIL burst_order[%0d]: got %h want %h", k, launched[k], 8'(k + 1)); end
        end
        for (int k = 0; k + 1 < start_cyc.size() && k < rise_cyc.size(); k++) begin
            checks++;
            if (start_cyc[k+1] - rise_cyc[k] != int'(GAP_CT) + 2) begin
                errors++; $display("FAIL burst_spacing[%0d]: got %0d cycles want %0d", k, start_cyc[k+1] - rise_cyc[k], GAP_CT + 2);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp[$];
        logic [7:0] d;
        bit to;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom_range(0, 254));
            exp.push_back(d);
            tick(1'b1, d, 1'b0, 1'b0);
        end
        tick(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d want 8", count); end
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle: got %b want 0", overflow); end
        tick(1'b1, 8'h77, 1'b0, 1'b1);
        exp.push_back(8'h77);
        checks++; if (count !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_write_pop: got count=%0d ovf=%b want 8 0", count, overflow); end
        checks++; if (enc_start !== 1'b1 || enc_data !== exp[0]) begin errors++; $display("FAIL ovf_pop_data: got start=%b data=%h want 1 %h", enc_start, enc_data, exp[0]); end
        clear_logs();
        encoder_run(900, to);
        checks++; if (to || launched.size() != exp.size()) begin errors++; $display("FAIL ovf_drain: got %0d launched timeout=%b want %0d", launched.size(), to, exp.size()); end
        for (int k = 0; k < launched.size() && k < exp.size(); k++) begin
            checks++; if (launched[k] !== exp[k]) begin errors++; $display("FAIL ovf_data[%0d]: got %h want %h", k, launched[k], exp[k]); end
        end
    endtask

    task automatic test_encoder_stall();
        logic [7:0] d[3];
        int bad;
        bit to;
        for (int i = 0; i < 3; i++) begin
            d[i] = 8'($urandom);
            tick(1'b1, d[i], 1'b0, 1'b0);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0);
            if (enc_start !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_no_launch: got %0d bad cycles want 0", bad); end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (enc_start !== 1'b1 || enc_data !== d[0]) begin errors++; $display("FAIL stall_release: got start=%b data=%h want 1 %h", enc_start, enc_data, d[0]); end
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b1);
            if (enc_start !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_ack_hold: got %0d bad cycles want 0", bad); end
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL stall_count: got %0d want 2", count); end
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        clear_logs();
        encoder_run(400, to);
        checks++; if (to || launched.size() != 2) begin errors++; $display("FAIL stall_drain: got %0d launched timeout=%b want 2", launched.size(), to); end
        else begin
            checks++; if (launched[0] !== d[1] || launched[1] !== d[2]) begin errors++; $display("FAIL stall_order: got %h %h want %h %h", launched[0], launched[1], d[1], d[2]); end
        end
    endtask

    task automatic test_flush();
        logic [7:0] first;
        int starts;
        first = 8'($urandom);
        tick(1'b1, first, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (enc_start !== 1'b1 || enc_data !== first) begin errors++; $display("FAIL flush_launch: got start=%b data=%h want 1 %h", enc_start, enc_data, first); end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_clear: got count=%0d empty=%b want 0 1", count, empty); end
        checks++; if (busy !== 1'b1 || enc_data !== first) begin errors++; $display("FAIL flush_inflight: got busy=%b data=%h want 1 %h", busy, enc_data, first); end
        starts = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b1);
            if (enc_start === 1'b1) starts++;
        end
        checks++; if (starts != 0 || busy !== 1'b0) begin errors++; $display("FAIL flush_no_more: got starts=%0d busy=%b want 0 0", starts, busy); end
        tick(1'b1, 8'h3C, 1'b1, 1'b1);
        checks++; if (count !== 4'd0 || overflow !== 1'b0) begin errors++; $display("FAIL flush_wr_drop: got count=%0d ovf=%b want 0 0", count, overflow); end
        for (int i = 0; i < 8; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
        tick(1'b1, 8'h5A, 1'b1, 1'b0);
        checks++; if (count !== 4'd0 || overflow !== 1'b0) begin errors++; $display("FAIL flush_full_wr: got count=%0d ovf=%b want 0 0", count, overflow); end
    endtask

    task automatic test_async_reset();
        int starts;
        tick(1'b1, 8'h11, 1'b0, 1'b1);
        tick(1'b1, 8'h22, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (m_ph != PH_GAP || busy !== 1'b1) begin errors++; $display("FAIL areset_setup_gap: got busy=%b want 1", busy); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (enc_start !== 1'b0 || busy !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL areset_gap: got start=%b busy=%b count=%0d want 0 0 0", enc_start, busy, count); end
        @(negedge clk);
        rst_n = 1'b1;
        starts = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b1);
            if (enc_start === 1'b1) starts++;
        end
        checks++; if (starts != 0) begin errors++; $display("FAIL areset_gap_quiet: got %0d starts want 0", starts); end
        tick(1'b1, 8'h33, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (enc_start !== 1'b1 || enc_data !== 8'h33) begin errors++; $display("FAIL areset_setup_start: got start=%b data=%h want 1 33", enc_start, enc_data); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (enc_start !== 1'b0 || busy !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL areset_start: got start=%b busy=%b count=%0d want 0 0 0", enc_start, busy, count); end
        checks++; if (enc_data !== 8'h00) begin errors++; $display("FAIL areset_data: got %h want 00", enc_data); end
        @(negedge clk);
        rst_n = 1'b1;
        starts = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b1);
            if (enc_start === 1'b1) starts++;
        end
        checks++; if (starts != 0) begin errors++; $display("FAIL areset_start_quiet: got %0d starts want 0", starts); end
    endtask

    task automatic test_random();
        bit av;
        bit we;
        bit fl;
        av = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            we = ($urandom_range(0, 99) < 45);
            fl = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 15) av = !av;
            tick(we, 8'($urandom), fl, av);
            checks++; if (count !== 4'(mq.size())) begin errors++; $display("FAIL rand_count @%0d: got %0d want %0d", cyc, count, mq.size()); end
            checks++; if (full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin errors++; $display("FAIL rand_flags @%0d: got full=%b empty=%b want size %0d", cyc, full, empty, mq.size()); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow @%0d: got %b want %b", cyc, overflow, m_ovf); end
            checks++; if (enc_start !== m_start) begin errors++; $display("FAIL rand_start @%0d: got %b want %b", cyc, enc_start, m_start); end
            checks++; if (enc_data !== m_data) begin errors++; $display("FAIL rand_data @%0d: got %h want %h", cyc, enc_data, m_data); end
            checks++; if (busy !== (m_ph != PH_IDLE)) begin errors++; $display("FAIL rand_busy @%0d: got %b want %b", cyc, busy, m_ph != PH_IDLE); end
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_burst_order();
        test_overflow();
        test_encoder_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
